// File: rtl/test_design_ctrl.sv
// Serial word-frame generator: per word, WORD_W data bits MSB first, then commit strobe, then gap.
// Define TEST_DESIGN_PARITY_EN to insert an even-parity bit between data and commit.
module test_design_ctrl #(
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned NUM_WORDS  = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [31:0] PATTERN    = 32'hA5
) (
  input  logic clk,
  input  logic rst,
  output logic en,
  output logic wr,
  output logic data
);

  localparam int unsigned BW = $clog2(WORD_W);
  localparam int unsigned IW =
    (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [BW-1:0] BIT_LAST =
    BW'(WORD_W - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_WORDS - 1);
  localparam logic [3:0] GAP_LAST =
    4'(GAP_CYCLES - 1);

`ifdef TEST_DESIGN_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, SHIFT, PARITY, COMMIT, GAP
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, SHIFT, COMMIT, GAP
  } state_e;
`endif

  state_e state_q, state_d;

  logic [BW-1:0] bit_q, bit_d;
  logic [3:0]    gap_q, gap_d;
  logic [IW-1:0] idx_q, idx_d;

  logic en_q, en_d;
  logic wr_q, wr_d;
  logic data_q, data_d;

  logic [WORD_W-1:0] word_d;

  function automatic logic [WORD_W-1:0] word_of(
    input logic [IW-1:0] i
  );
    return WORD_W'(PATTERN ^ 32'(i));
  endfunction

  function automatic logic [IW-1:0] idx_next(
    input logic [IW-1:0] i
  );
    return (i == IDX_LAST) ? '0 : i + 1'b1;
  endfunction

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        state_d = SHIFT;
        bit_d   = '0;
        idx_d   = '0;
      end
      SHIFT: begin
        if (bit_q == BIT_LAST) begin
`ifdef TEST_DESIGN_PARITY_EN
          state_d = PARITY;
`else
          state_d = COMMIT;
`endif
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
`ifdef TEST_DESIGN_PARITY_EN
      PARITY: state_d = COMMIT;
`endif
      COMMIT: begin
        if (GAP_CYCLES == 0) begin
          state_d = SHIFT;
          bit_d   = '0;
          idx_d   = idx_next(idx_q);
        end else begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = SHIFT;
          bit_d   = '0;
          idx_d   = idx_next(idx_q);
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        bit_d   = '0;
        gap_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    en_d   = 1'b0;
    wr_d   = 1'b0;
    data_d = 1'b0;
    word_d = word_of(idx_d);
    unique case (state_d)
      SHIFT: begin
        en_d   = 1'b1;
        data_d = word_d[BIT_LAST - bit_d];
      end
`ifdef TEST_DESIGN_PARITY_EN
      PARITY: begin
        en_d   = 1'b1;
        data_d = ^word_d;
      end
`endif
      COMMIT: begin
        en_d = 1'b1;
        wr_d = 1'b1;
      end
      default: begin
        en_d   = 1'b0;
        wr_d   = 1'b0;
        data_d = 1'b0;
      end
    endcase
  end

  assign en   = en_q;
  assign wr   = wr_q;
  assign data = data_q;

endmodule

// File: tb/tb_test_design_ctrl.sv
// Bench for test_design_ctrl: a reference stream of {en,wr,data}
// is queued per cycle and compared against two instances (gap 2 and gap 0).
module tb_test_design_ctrl;

  localparam int W = 8;
`ifdef TEST_DESIGN_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = W + PB + 1 + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst0 = 1'b1;
  logic en, wr, data;
  logic en0, wr0, data0;

  int vectors = 0;
  int errors = 0;

  logic [2:0] q[$];
  logic [2:0] q0[$];

  always #5 clk = ~clk;

  test_design_ctrl dut (
    .clk(clk), .rst(rst),
    .en(en), .wr(wr), .data(data)
  );

  test_design_ctrl #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0),
    .en(en0), .wr(wr0), .data(data0)
  );

  task automatic push_e(input bit sel, input logic [2:0] v);
    if (sel) q0.push_back(v);
    else q.push_back(v);
  endtask

  task automatic push_word(
    input int idx, input int gap, input int nbits, input bit sel
  );
    logic [7:0] w;
    w = 8'hA5 ^ 8'(idx);
    for (int b = 0; b < nbits; b++)
      push_e(sel, {1'b1, 1'b0, w[7-b]});
    if (nbits == W) begin
      if (PB == 1) push_e(sel, {1'b1, 1'b0, ^w});
      push_e(sel, 3'b110);
      for (int g = 0; g < gap; g++) push_e(sel, 3'b000);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({en, wr, data} !== 3'b000) begin
        errors++;
        $display("FAIL reset cyc%0d got %b exp 000", i, {en, wr, data});
      end
    end
    rst = 1'b0;
    vectors++;
    if ({en, wr, data} !== 3'b000) begin
      errors++;
      $display("FAIL idle got %b exp 000", {en, wr, data});
    end
  endtask

  task automatic test_frames;
    logic [2:0] exp;
    int k;
    for (int i = 0; i < 5; i++) push_word(i % 4, 2, W, 1'b0);
    k = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front();
      vectors++;
      if ({en, wr, data} !== exp) begin
        errors++;
        $display("FAIL frames k=%0d got %b exp %b", k, {en, wr, data}, exp);
      end
      k++;
    end
  endtask

  task automatic test_midframe_reset;
    logic [2:0] exp;
    int k;
    test_reset();
    push_word(0, 2, W, 1'b0);
    push_word(1, 2, W, 1'b0);
    push_word(2, 2, 5, 1'b0);
    k = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front();
      vectors++;
      if ({en, wr, data} !== exp) begin
        errors++;
        $display("FAIL pre_abort k=%0d got %b exp %b", k, {en, wr, data}, exp);
      end
      k++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({en, wr, data} !== 3'b000) begin
      errors++;
      $display("FAIL abort got %b exp 000", {en, wr, data});
    end
    push_word(0, 2, W, 1'b0);
    push_word(1, 2, W, 1'b0);
    k = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      exp = q.pop_front();
      vectors++;
      if ({en, wr, data} !== exp) begin
        errors++;
        $display("FAIL restart k=%0d got %b exp %b", k, {en, wr, data}, exp);
      end
      k++;
    end
  endtask

  task automatic test_no_gap;
    logic [2:0] exp;
    int k;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    vectors++;
    if ({en0, wr0, data0} !== 3'b000) begin
      errors++;
      $display("FAIL nogap_idle got %b exp 000", {en0, wr0, data0});
    end
    for (int i = 0; i < 6; i++) push_word(i % 4, 0, W, 1'b1);
    k = 0;
    while (q0.size() > 0) begin
      @(posedge clk); #1;
      exp = q0.pop_front();
      vectors++;
      if ({en0, wr0, data0} !== exp) begin
        errors++;
        $display("FAIL nogap k=%0d got %b exp %b", k, {en0, wr0, data0}, exp);
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_midframe_reset();
    test_no_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/test_design_ctrl.md
TEST_DESIGN_CTRL -- requirements
Module: test_design

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, meaning the width of each transmitted word (legal range 2..32).
REQ-002 The block SHALL have parameter NUM_WORDS, default 4, meaning the number of words per sequence (legal range 1..256).
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, meaning the idle cycles after each word (legal range 0..15).
REQ-004 The block SHALL have parameter PATTERN, default 8'hA5 zero-extended to WORD_W, meaning the base data pattern.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port en, output, 1 bit: high while a word frame (data, parity, commit) is on the bus.
REQ-008 The block SHALL have port wr, output, 1 bit: one-cycle write-commit strobe at the end of each word.
REQ-009 The block SHALL have port data, output, 1 bit: serial data bit.

Function
REQ-010 All outputs SHALL be driven directly from flip-flops, with no combinational path from any input.
REQ-011 The FSM SHALL have states IDLE, SHIFT, PARITY (present only with the macro), COMMIT and GAP.
REQ-012 Word i (i = 0..NUM_WORDS-1) SHALL equal PATTERN XOR i, truncated to WORD_W bits.
REQ-013 IDLE SHALL last exactly one cycle after reset release, with all outputs 0, then go to SHIFT with index 0.
REQ-014 SHIFT SHALL last WORD_W cycles with en=1, wr=0 and data = current word bits MSB first, one bit per cycle.
REQ-015 COMMIT SHALL last 1 cycle with en=1, wr=1 and data=0.
REQ-016 GAP SHALL last GAP_CYCLES cycles with en=0, wr=0 and data=0; if GAP_CYCLES=0, COMMIT SHALL go directly to SHIFT.
REQ-017 After GAP, the word index SHALL increment and wrap from NUM_WORDS-1 to 0; the sequence SHALL repeat indefinitely without revisiting IDLE.
REQ-018 wr SHALL never be high for more than one consecutive cycle, and SHALL never be high while en=0.
REQ-019 Frame period without the macro SHALL be WORD_W+1+GAP_CYCLES cycles per word (defaults: 11 per word, 44 per sequence).

Reset
REQ-020 While rst=1 at a rising edge, the FSM SHALL enter IDLE, clear the index and bit counters, and drive en=0, wr=0 and data=0 on that edge.
REQ-021 Reset asserted mid-frame (any state) SHALL abort the frame with no wr pulse, and the sequence SHALL restart at word 0 after IDLE.
REQ-022 There SHALL be no asynchronous reset path.

Configuration
REQ-023 With macro TEST_DESIGN_PARITY_EN defined, a PARITY state SHALL follow SHIFT for 1 cycle with en=1, wr=0 and data = XOR of all word bits (even parity); the frame period becomes WORD_W+2+GAP_CYCLES.
REQ-024 Without TEST_DESIGN_PARITY_EN, no PARITY state or parity logic SHALL exist, and SHIFT SHALL go directly to COMMIT.

Verification
REQ-025 Hold rst=1 for 3 cycles -> en=wr=data=0 during reset and during the first cycle after release.
REQ-026 Defaults, no macro -> first frame data = 1,0,1,0,0,1,0,1 (0xA5) with en=1 for 8 cycles; then wr=1 for 1 cycle; then 2 cycles with en=0.
REQ-027 Defaults, no macro -> second frame carries 0xA4 and fourth carries 0xA6; the fifth frame is 0xA5 again, 44 cycles after the first.
REQ-028 Defaults with TEST_DESIGN_PARITY_EN -> parity bit 0 after 0xA5 and 1 after 0xA4; wr follows the parity cycle; period 48 cycles.
REQ-029 Assert rst for 1 cycle during bit 4 of word 2 -> no wr pulse; after IDLE the next frame is 0xA5.
REQ-030 GAP_CYCLES=0 -> COMMIT is followed immediately by the next SHIFT, so en stays high continuously, and wr pulses every WORD_W+1 cycles.
